// File: rtl/sd_sector_buffer_if.sv
// rtl/sd_sector_buffer_if.sv - processor memory-mapped bus request signals
interface sd_sector_buffer_if;
  logic        wReadEnable;
  logic        wWriteEnable;
  logic [3:0]  wByteEnable;
  logic [31:0] wAddress;
  logic [31:0] wWriteData;

  modport master (
    output wReadEnable,
    output wWriteEnable,
    output wByteEnable,
    output wAddress,
    output wWriteData
  );

  modport slave (
    input wReadEnable,
    input wWriteEnable,
    input wByteEnable,
    input wAddress,
    input wWriteData
  );
endinterface

// File: rtl/sd_sector_buffer.sv
// rtl/sd_sector_buffer.sv - SD sector read buffer with memory-mapped control and data window
module sd_sector_buffer #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_1000,
  parameter logic [31:0] CTRL_OFFSET = 32'h0000_0200,
  parameter logic [31:0] SECT_OFFSET = 32'h0000_0204
) (
  input  logic                iCLK,
  input  logic                Reset,
  sd_sector_buffer_if.slave   bus,
  output wire  [31:0]         wReadData,
  output logic                oSDRead,
  output logic [31:0]         oSDAddress,
  input  logic                iSDBusy,
  input  logic                iSDByteValid,
  input  logic [7:0]          iSDData
);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFFSET;
  localparam logic [31:0] SECT_ADDR = BASE_ADDR + SECT_OFFSET;

  state_t      state, state_n;
  logic [9:0]  cnt;
  logic        overrun;
  logic [31:0] sect;
  logic [31:0] mem [128];

  logic        busy, done;
  logic        ctrl_hit, sect_hit, win_hit;
  logic        start_wr, sect_wr;
  logic        clear, store;
  logic [31:0] rd_data;
  logic        rd_hit;

  assign ctrl_hit = (bus.wAddress == CTRL_ADDR);
  assign sect_hit = (bus.wAddress == SECT_ADDR);
  assign win_hit  = (bus.wAddress[31:9] == BASE_ADDR[31:9]);
  assign start_wr = bus.wWriteEnable && ctrl_hit && bus.wByteEnable[0] && bus.wWriteData[0];
  assign sect_wr  = bus.wWriteEnable && sect_hit;
  assign busy     = (state == REQ) || (state == FILL);
  assign done     = (state == DONE);
  assign oSDAddress = sect;

  // Next-state logic plus per-cycle control strobes; start only accepted when no transaction is open
  always_comb begin
    state_n = state;
    clear   = 1'b0;
    store   = 1'b0;
    oSDRead = 1'b0;
    case (state)
      IDLE: begin
        if (start_wr) begin
          clear   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        oSDRead = 1'b1;
        if (iSDBusy) state_n = FILL;
      end
      FILL: begin
        if (iSDByteValid) begin
          store = 1'b1;
          if (cnt == 10'd511) state_n = DONE;
        end
      end
      DONE: begin
        if (start_wr) begin
          clear   = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, byte counter, overrun flag and sector-address register
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 10'd0;
      overrun <= 1'b0;
      sect    <= 32'd0;
    end else begin
      state <= state_n;
      if (clear) begin
        cnt     <= 10'd0;
        overrun <= 1'b0;
      end else begin
        if (store) cnt <= cnt + 10'd1;
        if (done && iSDByteValid) overrun <= 1'b1;
      end
      // Sector address is frozen while a transaction is in flight
      if (sect_wr && !busy) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.wByteEnable[i]) sect[8*i +: 8] <= bus.wWriteData[8*i +: 8];
        end
      end
    end
  end

  // Sector storage: little-endian byte packing, no reset so contents survive restarts
  always_ff @(posedge iCLK) begin
    if (store) mem[cnt[8:2]][{cnt[1:0], 3'b000} +: 8] <= iSDData;
  end

  // Combinational read decode; registers take precedence over the data window
  always_comb begin
    rd_data = 32'd0;
    rd_hit  = 1'b0;
    if (bus.wReadEnable) begin
      if (ctrl_hit) begin
        rd_hit  = 1'b1;
        rd_data = {6'd0, cnt, 13'd0, overrun, done, busy};
      end else if (sect_hit) begin
        rd_hit  = 1'b1;
        rd_data = sect;
      end else if (win_hit) begin
        rd_hit  = 1'b1;
        rd_data = mem[bus.wAddress[8:2]];
      end
    end
  end

  assign wReadData = rd_hit ? rd_data : 32'hzzzz_zzzz;

endmodule

// File: doc/sd_sector_buffer.md
# sd_sector_buffer

Receive-side stage directly downstream of the SD card SPI interface. Requests one 512-byte sector from the SD controller, captures the byte stream into an internal 128×32-bit buffer, and exposes the sector, a control/status register and a sector-address register on the processor's memory-mapped data bus. Software issues a read, polls status for completion, then reads the sector a word at a time.

## Interface
- BASE_ADDR, 32'hFFFF_1000: base of the 512-byte window; buffer words at BASE_ADDR+0x000..+0x1FC.
- CTRL_OFFSET, 32'h200: control/status register at BASE_ADDR+CTRL_OFFSET.
- SECT_OFFSET, 32'h204: sector-address register at BASE_ADDR+SECT_OFFSET.

- iCLK  in  1  single clock, all state on rising edge.
- Reset  in  1  synchronous, active-high.
- wReadEnable  in  1  bus read strobe.
- wWriteEnable  in  1  bus write strobe.
- wByteEnable  in  4  byte-lane enables for writes; SECT register honours them, CTRL uses lane 0 only.
- wAddress  in  32  bus address, word-aligned.
- wWriteData  in  32  bus write data.
- wReadData  out  32  bus read data; 32'hzzzzzzzz when not addressed or wReadEnable=0.
- oSDRead  out  1  read request to SD controller.
- oSDAddress  out  32  sector address to SD controller (= SECT register).
- iSDBusy  in  1  SD controller busy (1 = transaction in progress).
- iSDByteValid  in  1  one-cycle strobe, iSDData holds a valid received data byte.
- iSDData  in  8  received data byte.

## Operation
- States: IDLE, REQ, FILL, DONE.
- IDLE: CPU write to CTRL with wWriteData[0]=1 -> clear count, done, overrun; go REQ. Writes with bit0=0 have no effect.
- REQ: oSDRead=1. On iSDBusy=1 -> FILL, oSDRead=0 next cycle.
- FILL: each iSDByteValid stores iSDData at byte index cnt (0..511): word cnt[8:2], lane cnt[1:0] (little-endian: byte 0 in bits 7:0). cnt increments. Strobe with cnt=511 -> DONE.
- DONE: done=1. Further iSDByteValid strobes discarded, overrun=1. CTRL start write -> behaves as in IDLE (new request).
- Start writes in REQ or FILL ignored; SECT writes in REQ or FILL ignored (oSDAddress stable during a transaction).
- CTRL read value: bit0 busy (REQ or FILL), bit1 done, bit2 overrun, bits 25:16 = cnt (10-bit, 0..512), all else 0.
- Buffer read: wReadData = mem[wAddress[8:2]] when wAddress in window. Buffer contents persist across requests until overwritten; not cleared by start.
- SECT read returns SECT register.
- Buffer not CPU-writable; bus writes to window ignored.

## Timing
- Reset (cycle after Reset sampled high): state IDLE, oSDRead=0, oSDAddress=0, cnt=0, done=0, overrun=0. Buffer contents undefined. Reset mid-FILL aborts; subsequent SD bytes ignored (IDLE).
- oSDRead rises 1 cycle after the CTRL start write; falls 1 cycle after iSDBusy first sampled high.
- iSDBusy already high when REQ entered -> FILL after one REQ cycle (oSDRead high exactly 1 cycle).
- Byte written at the strobe edge; readable on bus the following cycle. cnt, done update at the same edge.
- done=1 and busy=0 visible the cycle after the 512th strobe.
- wReadData combinational from address/registers; zero-wait-state bus.
- Bus write to CTRL coinciding with the 512th strobe: strobe completes (DONE); start ignored.
- iSDByteValid in IDLE or REQ ignored.

## Test plan
- Reset: assert Reset 2 cycles -> oSDRead=0, oSDAddress=0, CTRL reads 0x00000000.
- Write SECT=0x00000010, CTRL=1; hold iSDBusy=0 3 cycles then 1 -> oSDRead high 4 cycles, oSDAddress=0x10, CTRL bit0=1.
- Stream bytes n&0xFF, n=0..511 -> CTRL=0x02000002; word 0 = 0x03020100, word 127 (BASE+0x1FC) = 0xFFFEFDFC.
- After DONE, 3 extra strobes -> CTRL=0x02000006, word 0 unchanged.
- Reset after 100 bytes, then 10 strobes -> CTRL=0; new start + full sector completes normally.
- Start write and SECT write during FILL -> no restart, oSDAddress unchanged, cnt continues.
